// File: rtl/ifetch_line_ctrl_pkg.sv
// ifetch_line_ctrl_pkg: shared fetch FSM states and line geometry constants.
package ifetch_line_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  localparam int LINE_BYTES = 16;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS = 2;
  localparam int CNT_W = WORD_IDX_BITS + 1;
endpackage

// File: rtl/ifetch_line_ctrl_if.sv
// ifetch_line_ctrl_if: queue-side and memory-side signals of the line fetcher.
// IFETCH_PERF_CNT_EN adds the performance counter outputs.
interface ifetch_line_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
);
  logic i_rd_en;
  logic [ADDR_WIDTH-1:0] i_pc_in;
  logic i_flush;
  logic o_mem_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic i_mem_ready;
  logic i_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic [DATA_WIDTH*LINE_WORDS-1:0] o_dout;
  logic o_dout_valid;
  logic o_busy;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] o_perf_lines;
  logic [15:0] o_perf_drops;
`endif
  modport slave (
    input i_rd_en, i_pc_in, i_flush, i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_mem_req, o_mem_addr, o_dout, o_dout_valid, o_busy
`ifdef IFETCH_PERF_CNT_EN
    , output o_perf_lines, o_perf_drops
`endif
  );
  modport master (
    output i_rd_en, i_pc_in, i_flush, i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input o_mem_req, o_mem_addr, o_dout, o_dout_valid, o_busy
`ifdef IFETCH_PERF_CNT_EN
    , input o_perf_lines, o_perf_drops
`endif
  );
endinterface

// File: rtl/ifetch_line_asm.sv
// ifetch_line_asm: four-slot line assembly register; o_line shows the slots with this cycle's write merged in.
module ifetch_line_asm
  import ifetch_line_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clr,
  input  logic                             i_we,
  input  logic [WORD_IDX_BITS-1:0]         i_idx,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] o_line
);
  logic [DATA_WIDTH-1:0] r_slot [LINE_WORDS];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int k = 0; k < LINE_WORDS; k++) r_slot[k] <= '0;
    end else if (i_we) begin
      r_slot[i_idx] <= i_data;
    end
  end
  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_slot
    assign o_line[g*DATA_WIDTH +: DATA_WIDTH] =
      (i_we && i_idx == WORD_IDX_BITS'(g)) ? i_data : r_slot[g];
  end
endmodule

// File: rtl/ifetch_line_ctrl.sv
// ifetch_line_ctrl: fetches a 16-byte line as four memory words and hands it to the fetch queue.
// Defining IFETCH_PERF_CNT_EN adds completed-line and dropped-response counters.
module ifetch_line_ctrl
  import ifetch_line_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  ifetch_line_ctrl_if.slave bus
);
  localparam int LINE_W = DATA_WIDTH * LINE_WORDS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_issue, r_recv, r_drain, w_pend, w_rem;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic [LINE_W-1:0] r_dout, w_line;
  logic r_dout_valid, w_active, w_kill, w_req, w_acc, w_rx, w_drx, w_done, w_start;

  assign w_active = (r_state == REQ) || (r_state == WAIT);
  assign w_kill = w_active && bus.i_flush;
  assign w_req = (r_state == REQ) && !bus.i_flush;
  assign w_acc = w_req && bus.i_mem_ready;
  // a response may pair with the word accepted in the same cycle
  assign w_pend = r_issue + CNT_W'(w_acc) - r_recv;
  assign w_rx = w_active && bus.i_mem_rvalid && (w_pend != '0);
  assign w_rem = r_issue - r_recv - CNT_W'(w_rx);
  assign w_drx = (r_state == DRAIN) && bus.i_mem_rvalid;
  assign w_done = w_rx && !bus.i_flush && (r_recv == LAST);
  assign w_start = (r_state == IDLE) && bus.i_rd_en && !bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_start ? REQ : IDLE;
      REQ, WAIT: w_next = bus.i_flush ? ((w_rem != '0) ? DRAIN : IDLE)
                        : w_done ? IDLE
                        : (r_state == REQ && w_acc && r_issue == LAST) ? WAIT : r_state;
      DRAIN:     w_next = (w_drx && r_drain == CNT_W'(1)) ? IDLE : DRAIN;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_mem_req = w_req;
    bus.o_mem_addr = r_line_addr + ADDR_WIDTH'({r_issue, 2'b00});
    bus.o_busy = r_state != IDLE;
    bus.o_dout = r_dout;
    bus.o_dout_valid = r_dout_valid;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_issue <= '0;
      r_recv <= '0;
      r_drain <= '0;
      r_line_addr <= '0;
      r_dout <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_done;
      if (w_start) r_line_addr <= {bus.i_pc_in[ADDR_WIDTH-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
      if (w_done) r_dout <= w_line;
      r_issue <= (w_done || w_kill) ? '0 : r_issue + CNT_W'(w_acc);
      r_recv <= (w_done || w_kill) ? '0 : r_recv + CNT_W'(w_rx);
      r_drain <= w_kill ? w_rem : r_drain - CNT_W'(w_drx);
    end
  end

  ifetch_line_asm #(.DATA_WIDTH(DATA_WIDTH), .LINE_WORDS(LINE_WORDS)) u_asm (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_clr(w_kill),
    .i_we(w_rx && !bus.i_flush),
    .i_idx(r_recv[WORD_IDX_BITS-1:0]),
    .i_data(bus.i_mem_rdata),
    .o_line(w_line)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_perf_lines;
  logic [15:0] r_perf_drops;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_perf_lines <= '0;
      r_perf_drops <= '0;
    end else begin
      r_perf_lines <= r_perf_lines + 32'(w_done);
      r_perf_drops <= r_perf_drops + 16'(w_drx || (w_rx && bus.i_flush));
    end
  end
  assign bus.o_perf_lines = r_perf_lines;
  assign bus.o_perf_drops = r_perf_drops;
`endif
endmodule
